// File: rtl/pipe_power_manager_pkg.sv
// Shared types for the PIPE power manager: power-state codes as they appear
// on PWRDDWN/PSTATE, FSM state encoding, counter width helper and the
// mapping from a requested power state to its settled FSM state.
package pipe_power_manager_pkg;

  typedef enum logic [1:0] {
    PS_P0  = 2'b00,
    PS_P0S = 2'b01,
    PS_P1  = 2'b10,
    PS_P2  = 2'b11
  } pstate_e;

  typedef enum logic [3:0] {
    S_INIT, S_P0, S_P0S, S_P1, S_P2, S_ENTER, S_EXIT, S_DETECT, S_LOOPB
  } state_e;

  // Wide enough to hold (max latency - 1) with one bit of headroom.
  function automatic int cnt_width(input int a, input int b, input int c,
                                   input int d, input int e, input int f);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    if (f > m) m = f;
    return $clog2(m) + 1;
  endfunction

  function automatic state_e settled(input pstate_e p);
    state_e s;
    case (p)
      PS_P0S:  s = S_P0S;
      PS_P1:   s = S_P1;
      PS_P2:   s = S_P2;
      default: s = S_P0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pipe_power_manager_if.sv
// MAC <-> PHY power-management bundle.
//  master (MAC side): drives PWRDDWN, RXDET_LOOPB, RXDET_O (analog comparators
//                     are bundled here for convenience); reads the status set.
//  slave  (PHY side): PSTATE, CLK_EN_INTER, CLK_EN_TRANS, RXLOOPB, TXIDLE,
//                     RXDET, PHYSTATUS.
interface pipe_power_manager_if
  import pipe_power_manager_pkg::*;
  #(parameter int LANES = 4);

  logic [1:0]       PWRDDWN;
  logic             RXDET_LOOPB;
  logic [LANES-1:0] RXDET_O;
  pstate_e          PSTATE;
  logic             CLK_EN_INTER;
  logic             CLK_EN_TRANS;
  logic [LANES-1:0] RXLOOPB;
  logic [LANES-1:0] TXIDLE;
  logic [LANES-1:0] RXDET;
  logic             PHYSTATUS;

  modport master (
    output PWRDDWN, RXDET_LOOPB, RXDET_O,
    input  PSTATE, CLK_EN_INTER, CLK_EN_TRANS, RXLOOPB, TXIDLE, RXDET, PHYSTATUS
  );

  modport slave (
    input  PWRDDWN, RXDET_LOOPB, RXDET_O,
    output PSTATE, CLK_EN_INTER, CLK_EN_TRANS, RXLOOPB, TXIDLE, RXDET, PHYSTATUS
  );

endinterface

// File: rtl/pipe_power_manager_delay_cnt.sv
// Shared loadable down-counter for all power-manager latencies.
//  clk   : REFCLK
//  load  : load value (takes priority)
//  value : count to load (latency - 1)
//  tick  : decrement enable
//  done  : count is zero; the counter parks there and never wraps
module pm_delay_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             tick,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (load)                   cnt <= value;
    else if (tick && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/pipe_power_manager.sv
// Multi-lane PIPE power-state controller (REFCLK domain).
// Sequences P0/P0s/P1/P2 entry/exit with programmable latencies, receiver
// detect in P1 and loopback in P0; completion is reported on PHYSTATUS.
//  REFCLK : clock, rising edge
//  RESET  : synchronous, active high; aborts any operation, restarts init
//  bus    : slave side of pipe_power_manager_if (requests in, status out)
module pipe_power_manager
  import pipe_power_manager_pkg::*;
#(
  parameter int LANES        = 4,
  parameter int INIT_CYC     = 64,
  parameter int ENTRY_CYC    = 4,
  parameter int P0S_EXIT_CYC = 8,
  parameter int P1_EXIT_CYC  = 32,
  parameter int P2_EXIT_CYC  = 128,
  parameter int RXDET_CYC    = 16
) (
  input  logic                 REFCLK,
  input  logic                 RESET,
  pipe_power_manager_if.slave  bus
);

  localparam int CNT_W = cnt_width(INIT_CYC, ENTRY_CYC, P0S_EXIT_CYC,
                                   P1_EXIT_CYC, P2_EXIT_CYC, RXDET_CYC);
  localparam logic [CNT_W-1:0] INIT_LEN  = CNT_W'(INIT_CYC - 1);
  localparam logic [CNT_W-1:0] ENTRY_LEN = CNT_W'(ENTRY_CYC - 1);
  localparam logic [CNT_W-1:0] P0S_LEN   = CNT_W'(P0S_EXIT_CYC - 1);
  localparam logic [CNT_W-1:0] P1_LEN    = CNT_W'(P1_EXIT_CYC - 1);
  localparam logic [CNT_W-1:0] P2_LEN    = CNT_W'(P2_EXIT_CYC - 1);
  localparam logic [CNT_W-1:0] RXDET_LEN = CNT_W'(RXDET_CYC - 1);

  state_e           state;
  pstate_e          target;
  pstate_e          req;
  logic             armed;      // detect may start; re-armed by RXDET_LOOPB low
  logic             go_enter, go_exit, start_det;
  logic             cnt_load, cnt_tick, cnt_done;
  logic [CNT_W-1:0] cnt_value, exit_len;

  assign req = pstate_e'(bus.PWRDDWN);

  // Decisions shared by the counter load and the FSM so they never disagree.
  assign go_enter  = (state inside {S_P0, S_LOOPB}) && (req != PS_P0);
  assign go_exit   = (state inside {S_P0S, S_P1, S_P2}) && (req == PS_P0);
  // A power change in the same cycle takes precedence over detect.
  assign start_det = (state == S_P1) && (req != PS_P0) && bus.RXDET_LOOPB && armed;

  always_comb begin
    case (state)
      S_P0S:   exit_len = P0S_LEN;
      S_P1:    exit_len = P1_LEN;
      default: exit_len = P2_LEN;
    endcase
  end

  always_comb begin
    cnt_value = INIT_LEN;
    if (!RESET) begin
      if (go_enter)     cnt_value = ENTRY_LEN;
      else if (go_exit) cnt_value = exit_len;
      else              cnt_value = RXDET_LEN;
    end
  end

  assign cnt_load = RESET | go_enter | go_exit | start_det;
  assign cnt_tick = state inside {S_INIT, S_ENTER, S_EXIT, S_DETECT};

  pm_delay_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk   (REFCLK),
    .load  (cnt_load),
    .value (cnt_value),
    .tick  (cnt_tick),
    .done  (cnt_done)
  );

  always_ff @(posedge REFCLK) begin
    if (RESET) begin
      state            <= S_INIT;
      target           <= PS_P0;
      armed            <= 1'b1;
      bus.PSTATE       <= PS_P0;
      bus.CLK_EN_INTER <= 1'b1;
      bus.CLK_EN_TRANS <= 1'b1;
      bus.RXLOOPB      <= '0;
      bus.TXIDLE       <= '1;
      bus.RXDET        <= '0;
      bus.PHYSTATUS    <= 1'b1;
    end else begin
      bus.PHYSTATUS <= 1'b0;
      if (!bus.RXDET_LOOPB) armed <= 1'b1;
      case (state)
        S_INIT:
          if (cnt_done) begin
            state      <= S_P0;
            bus.TXIDLE <= '0;
          end else begin
            bus.PHYSTATUS <= 1'b1;
          end
        S_P0, S_LOOPB:
          if (go_enter) begin
            state       <= S_ENTER;
            target      <= req;
            bus.TXIDLE  <= '1;
            bus.RXLOOPB <= '0;
          end else if (bus.RXDET_LOOPB) begin
            state       <= S_LOOPB;
            bus.RXLOOPB <= '1;
          end else begin
            state       <= S_P0;
            bus.RXLOOPB <= '0;
          end
        S_P0S, S_P1, S_P2:
          if (go_exit) begin
            state  <= S_EXIT;
            target <= PS_P0;
            // PLL relocks during the exit latency.
            if (state == S_P2) begin
              bus.CLK_EN_INTER <= 1'b1;
              bus.CLK_EN_TRANS <= 1'b1;
            end
          end else if (start_det) begin
            state <= S_DETECT;
            armed <= 1'b0;
          end
        S_ENTER, S_EXIT:
          if (cnt_done) begin
            state         <= settled(target);
            bus.PSTATE    <= target;
            bus.PHYSTATUS <= 1'b1;
            if (target == PS_P0) bus.TXIDLE <= '0;
            if (target == PS_P2) begin
              bus.CLK_EN_INTER <= 1'b0;
              bus.CLK_EN_TRANS <= 1'b0;
            end
          end
        S_DETECT:
          if (cnt_done) begin
            state         <= S_P1;
            bus.RXDET     <= bus.RXDET_O;
            bus.PHYSTATUS <= 1'b1;
          end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule
